// File: rtl/upsampler_pkg.sv
// Shared types and sizing helpers for the nearest-neighbour stream upsampler.
package upsampler_pkg;

  typedef enum logic [0:0] {
    StLive,
    StReplay
  } state_e;

  // Counter width for a count of n values; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsampler_line_buffer.sv
// Simple dual-port line store: one write port, one registered read port.
module upsampler_line_buffer #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 320,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/upsampler_stream.sv
// Streaming nearest-neighbour upscaler: live line passes through with pixel repeats,
// then the buffered line is replayed FACTOR-1 more times.
module upsampler_stream
  import upsampler_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LINE_W = 320,
  parameter int unsigned FACTOR = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              fifo_read,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  input  logic              readyout,
  output logic              eolout
);

  localparam int unsigned XW = cnt_w(LINE_W);
  localparam int unsigned RW = cnt_w(FACTOR);
  localparam logic [XW-1:0] XLast = XW'(LINE_W - 1);
  localparam logic [RW-1:0] RLast = RW'(FACTOR - 1);

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [RW-1:0]     pass_q, pass_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vout_q, vout_d;
  logic              eol_q, eol_d;
  logic              slot_free, emit;
  logic [DATA_W-1:0] pix, rdata;

  // Read address follows next-state x so rdata always holds buf[x_q] during replay.
  upsampler_line_buffer #(
    .DataW(DATA_W),
    .Depth(LINE_W),
    .AddrW(XW)
  ) u_line_buffer (
    .clk_i  (clock),
    .we_i   (fifo_read && valid),
    .waddr_i(x_q),
    .wdata_i(data),
    .raddr_i(x_d),
    .rdata_o(rdata)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    rep_d     = rep_q;
    pass_d    = pass_q;
    dout_d    = dout_q;
    vout_d    = vout_q;
    eol_d     = eol_q;
    emit      = 1'b0;
    pix       = dout_q;
    fifo_read = 1'b0;
    slot_free = !vout_q || readyout;
    if (slot_free) begin
      vout_d = 1'b0;
      eol_d  = 1'b0;
    end
    unique case (state_q)
      StLive: begin
        fifo_read = slot_free && (rep_q == '0) && !reset;
        if (slot_free) begin
          // Repeats re-emit the pixel still sitting in the output register.
          if (rep_q == '0) begin
            emit = valid;
            pix  = data;
          end else begin
            emit = 1'b1;
          end
        end
      end
      StReplay: begin
        emit = slot_free;
        pix  = rdata;
      end
      default: ;
    endcase
    if (emit) begin
      dout_d = pix;
      vout_d = 1'b1;
      eol_d  = (x_q == XLast) && (rep_q == RLast);
      if (rep_q == RLast) begin
        rep_d = '0;
        if (x_q == XLast) begin
          x_d = '0;
          if (state_q == StLive) begin
            if (FACTOR > 1) begin
              state_d = StReplay;
              pass_d  = RW'(1);
            end
          end else if (pass_q == RLast) begin
            state_d = StLive;
            pass_d  = '0;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StLive;
      x_q     <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      eol_q   <= eol_d;
    end
  end

  assign dataout  = dout_q;
  assign validout = vout_q;
  assign eolout   = eol_q;

endmodule

// File: tb/tb_upsampler_stream.sv
// Bench for upsampler_stream: three instances (FACTOR 2, 3, 1; LINE_W 4) checked against
// an arithmetic model of the upscaled raster.
module tb_upsampler_stream;

  localparam int W = 4;

  logic       clock;
  logic       reset;
  logic       valid     [3];
  logic [7:0] data      [3];
  logic       fifo_read [3];
  logic [7:0] dataout   [3];
  logic       validout  [3];
  logic       readyout  [3];
  logic       eolout    [3];

  int checks = 0;
  int errors = 0;

  int src_mem [3][256];
  int src_wr [3], src_rd [3];
  int acc_mem [3][256];
  int acc_n [3], out_n [3], eol_n [3];
  bit acc_now [3], prev_acc [3], prev_stall [3];
  int prev_in [3], prev_dout [3];
  bit prev_v [3], prev_e [3];
  int gap_pct [3], ready_pct [3], stall_cnt [3];

  upsampler_stream #(.DATA_W(8), .LINE_W(W), .FACTOR(2)) u_f2 (
    .clock(clock), .reset(reset), .valid(valid[0]), .data(data[0]), .fifo_read(fifo_read[0]),
    .dataout(dataout[0]), .validout(validout[0]), .readyout(readyout[0]), .eolout(eolout[0])
  );
  upsampler_stream #(.DATA_W(8), .LINE_W(W), .FACTOR(3)) u_f3 (
    .clock(clock), .reset(reset), .valid(valid[1]), .data(data[1]), .fifo_read(fifo_read[1]),
    .dataout(dataout[1]), .validout(validout[1]), .readyout(readyout[1]), .eolout(eolout[1])
  );
  upsampler_stream #(.DATA_W(8), .LINE_W(W), .FACTOR(1)) u_f1 (
    .clock(clock), .reset(reset), .valid(valid[2]), .data(data[2]), .fifo_read(fifo_read[2]),
    .dataout(dataout[2]), .validout(validout[2]), .readyout(readyout[2]), .eolout(eolout[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int fac(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    src_mem[k][src_wr[k]] = v;
    src_wr[k]++;
  endtask

  task automatic wait_out(input int k, input int n);
    for (int c = 0; c < 3000 && out_n[k] < n; c++) @(posedge clock);
    chk("timeout", k, 32'(out_n[k] >= n), 32'd1);
  endtask

  // Expected output n of a stream: line L, row pos, source pixel pos/F of that line.
  task automatic check_output(input int k);
    int f, row, per_line, n, l, m, pos, idx;
    f        = fac(k);
    row      = f * W;
    per_line = f * row;
    n        = out_n[k];
    l        = n / per_line;
    m        = n % per_line;
    pos      = m % row;
    idx      = l * W + pos / f;
    chk("order", k, 32'(idx < acc_n[k]), 32'd1);
    if (idx < acc_n[k]) chk("pixel", k, 32'(dataout[k]), 32'(acc_mem[k][idx]));
    chk("eol", k, 32'(eolout[k]), 32'(pos == row - 1));
    if (m >= row) chk("no_read_replay", k, 32'(acc_n[k]), 32'(W * (l + 1)));
    if (eolout[k]) eol_n[k]++;
    out_n[k]++;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          out_n[k] = 0; acc_n[k] = 0; eol_n[k] = 0;
          acc_now[k] = 0; prev_acc[k] = 0; prev_stall[k] = 0;
        end else begin
          if (prev_acc[k]) begin
            chk("latency_v", k, 32'(validout[k]), 32'd1);
            chk("latency_d", k, 32'(dataout[k]), 32'(prev_in[k]));
          end
          if (prev_stall[k]) begin
            chk("hold_v", k, 32'(validout[k]), 32'(prev_v[k]));
            chk("hold_d", k, 32'(dataout[k]), 32'(prev_dout[k]));
            chk("hold_e", k, 32'(eolout[k]), 32'(prev_e[k]));
          end
          if (validout[k] && readyout[k]) check_output(k);
          acc_now[k] = valid[k] && fifo_read[k];
          if (acc_now[k]) begin
            acc_mem[k][acc_n[k]] = data[k];
            acc_n[k]++;
          end
          prev_acc[k]   = acc_now[k];
          prev_in[k]    = data[k];
          prev_stall[k] = validout[k] && !readyout[k];
          prev_v[k]     = validout[k];
          prev_dout[k]  = dataout[k];
          prev_e[k]     = eolout[k];
        end
      end
    end
  end

  // Source/sink drivers: source holds an offered pixel until it is taken.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          valid[k]  = 1'b0;
          src_rd[k] = src_wr[k];
        end else begin
          if (acc_now[k]) src_rd[k]++;
          if (!(valid[k] && !acc_now[k])) begin
            if (src_rd[k] != src_wr[k] && $urandom_range(99) >= gap_pct[k]) begin
              valid[k] = 1'b1;
              data[k]  = 8'(src_mem[k][src_rd[k]]);
            end else begin
              valid[k] = 1'b0;
              data[k]  = 8'($urandom_range(255));
            end
          end
        end
        if (stall_cnt[k] > 0) begin
          readyout[k] = 1'b0;
          stall_cnt[k]--;
        end else begin
          readyout[k] = ($urandom_range(99) < ready_pct[k]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0; data[k] = 8'd0; readyout[k] = 1'b0;
      gap_pct[k] = 0; ready_pct[k] = 100; stall_cnt[k] = 0;
      src_wr[k] = 0; src_rd[k] = 0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_validout", k, 32'(validout[k]), 32'd0);
      chk("rst_eolout", k, 32'(eolout[k]), 32'd0);
      chk("rst_dataout", k, 32'(dataout[k]), 32'd0);
      chk("rst_fifo_read", k, 32'(fifo_read[k]), 32'd0);
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Basic 2x line, continuous ready.
    push(0, 10); push(0, 20); push(0, 30); push(0, 40);
    wait_out(0, 16);
    chk("eol_count_basic", 0, 32'(eol_n[0]), 32'd2);

    // Three-cycle downstream stall mid-line.
    push(0, 11); push(0, 22); push(0, 33); push(0, 44);
    wait_out(0, 21);
    stall_cnt[0] = 3;
    wait_out(0, 32);

    // Valid held high across three back-to-back lines.
    for (int i = 0; i < 12; i++) push(0, $urandom_range(255));
    wait_out(0, 80);
    chk("consumed_cont", 0, 32'(acc_n[0]), 32'd20);

    // FACTOR=1 pass-through.
    push(2, 1); push(2, 2); push(2, 3);
    wait_out(2, 3);
    push(2, 4);
    wait_out(2, 4);

    // Random data with random gaps and backpressure on all instances.
    for (int k = 0; k < 3; k++) begin
      gap_pct[k] = 30;
      ready_pct[k] = 70;
    end
    for (int i = 0; i < 8; i++) push(0, $urandom_range(255));
    for (int i = 0; i < 12; i++) push(1, $urandom_range(255));
    for (int i = 0; i < 12; i++) push(2, $urandom_range(255));
    wait_out(0, 112);
    wait_out(1, 108);
    wait_out(2, 16);
    chk("f3_outputs", 1, 32'(out_n[1]), 32'd108);
    chk("f3_eol_pulses", 1, 32'(eol_n[1]), 32'd9);
    chk("f3_consumed", 1, 32'(acc_n[1]), 32'd12);
    chk("f1_eol_pulses", 2, 32'(eol_n[2]), 32'd4);
    chk("f2_consumed", 0, 32'(acc_n[0]), 32'd28);

    // Reset during replay pass 1, then a fresh line.
    gap_pct[0] = 0;
    ready_pct[0] = 100;
    for (int i = 0; i < 4; i++) push(0, 100 + i);
    wait_out(0, 123);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_validout", 0, 32'(validout[0]), 32'd0);
    chk("rst_mid_eolout", 0, 32'(eolout[0]), 32'd0);
    chk("rst_mid_dataout", 0, 32'(dataout[0]), 32'd0);
    chk("rst_mid_fifo_read", 0, 32'(fifo_read[0]), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    push(0, 5); push(0, 6); push(0, 7); push(0, 8);
    wait_out(0, 16);
    repeat (5) @(posedge clock);
    chk("post_rst_outputs", 0, 32'(out_n[0]), 32'd16);
    chk("post_rst_eol", 0, 32'(eol_n[0]), 32'd2);
    chk("post_rst_consumed", 0, 32'(acc_n[0]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
